// File: rtl/tri_seq_monitor_if.sv
// rtl/tri_seq_monitor_if.sv - counter-under-test bus and monitor result signals
// err_cnt exists only when TRI_SEQ_MONITOR_ERR_CNT_EN is defined.
interface tri_seq_monitor_if #(
   parameter int W  = 3,
   parameter int PW = 8
);
   logic [W-1:0]  cnt_in;
   logic          cnt_vld;
   logic          dir;
   logic          locked;
   logic          at_top;
   logic          at_bot;
   logic          err;
   logic          err_sticky;
   logic [PW-1:0] period_cnt;
`ifdef TRI_SEQ_MONITOR_ERR_CNT_EN
   logic [7:0]    err_cnt;
`endif

   modport master (
      output cnt_in, cnt_vld,
      input  dir, locked, at_top, at_bot, err, err_sticky, period_cnt
`ifdef TRI_SEQ_MONITOR_ERR_CNT_EN
      , input err_cnt
`endif
   );

   modport slave (
      input  cnt_in, cnt_vld,
      output dir, locked, at_top, at_bot, err, err_sticky, period_cnt
`ifdef TRI_SEQ_MONITOR_ERR_CNT_EN
      , output err_cnt
`endif
   );
endinterface

// File: rtl/tri_seq_monitor.sv
// rtl/tri_seq_monitor.sv - checker for a bouncing MIN..MAX..MIN up/down counter
// Optional saturating error counter: TRI_SEQ_MONITOR_ERR_CNT_EN.
module tri_seq_monitor #(
   parameter int W   = 3,
   parameter int MIN = 0,
   parameter int MAX = 5,
   parameter int PW  = 8
) (
   input logic              clk,
   input logic              rst,
   tri_seq_monitor_if.slave io_bus
);
   localparam logic [W:0] L_MIN = (W+1)'(MIN);
   localparam logic [W:0] L_MAX = (W+1)'(MAX);

   typedef enum logic [1:0] {S_IDLE, S_ACQ, S_UP, S_DOWN} state_t;

   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_prev, w_prev_nxt;
   logic          r_at_top, w_top_nxt;
   logic          r_at_bot, w_bot_nxt;
   logic          r_err, w_err_nxt;
   logic          r_err_sticky;
   logic [PW-1:0] r_period, w_period_nxt;

   // One extra bit keeps prev-1 at zero from aliasing onto a legal value.
   logic [W:0]    w_s, w_inc, w_dec;
   logic          w_in_rng, w_up_ok, w_dn_ok, w_is_max, w_is_min;

   assign w_s      = {1'b0, io_bus.cnt_in};
   assign w_inc    = {1'b0, r_prev} + (W+1)'(1);
   assign w_dec    = {1'b0, r_prev} - (W+1)'(1);
   assign w_in_rng = (w_s >= L_MIN) && (w_s <= L_MAX);
   assign w_up_ok  = (w_s == w_inc) && (w_s <= L_MAX);
   assign w_dn_ok  = (w_s == w_dec) && (w_s >= L_MIN);
   assign w_is_max = (w_s == L_MAX);
   assign w_is_min = (w_s == L_MIN);

   always_comb begin
      w_state_nxt  = r_state;
      w_prev_nxt   = r_prev;
      w_top_nxt    = 1'b0;
      w_bot_nxt    = 1'b0;
      w_err_nxt    = 1'b0;
      w_period_nxt = r_period;
      if (io_bus.cnt_vld) begin
         w_prev_nxt = io_bus.cnt_in;
         unique case (r_state)
            S_IDLE: w_state_nxt = S_ACQ;
            S_ACQ: begin
               if (w_up_ok || w_dn_ok) begin
                  w_top_nxt = w_is_max;
                  w_bot_nxt = w_is_min;
                  if (w_up_ok) w_state_nxt = w_is_max ? S_DOWN : S_UP;
                  else         w_state_nxt = w_is_min ? S_UP : S_DOWN;
               end
            end
            S_UP: begin
               if ((w_s == w_inc) && w_in_rng) begin
                  if (w_is_max) begin
                     w_state_nxt = S_DOWN;
                     w_top_nxt   = 1'b1;
                  end
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_ACQ;
               end
            end
            S_DOWN: begin
               if ((w_s == w_dec) && w_in_rng) begin
                  if (w_is_min) begin
                     w_state_nxt  = S_UP;
                     w_bot_nxt    = 1'b1;
                     w_period_nxt = r_period + PW'(1);
                  end
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_ACQ;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_prev       <= '0;
         r_at_top     <= 1'b0;
         r_at_bot     <= 1'b0;
         r_err        <= 1'b0;
         r_err_sticky <= 1'b0;
         r_period     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev       <= w_prev_nxt;
         r_at_top     <= w_top_nxt;
         r_at_bot     <= w_bot_nxt;
         r_err        <= w_err_nxt;
         r_err_sticky <= r_err_sticky | w_err_nxt;
         r_period     <= w_period_nxt;
      end
   end

`ifdef TRI_SEQ_MONITOR_ERR_CNT_EN
   logic [7:0] r_err_cnt;
   always_ff @(posedge clk) begin
      if (rst)                                r_err_cnt <= 8'd0;
      else if (w_err_nxt && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
   end
   assign io_bus.err_cnt = r_err_cnt;
`endif

   assign io_bus.dir        = (r_state == S_DOWN);
   assign io_bus.locked     = (r_state == S_UP) || (r_state == S_DOWN);
   assign io_bus.at_top     = r_at_top;
   assign io_bus.at_bot     = r_at_bot;
   assign io_bus.err        = r_err;
   assign io_bus.err_sticky = r_err_sticky;
   assign io_bus.period_cnt = r_period;
endmodule

// File: tb/tb_tri_seq_monitor.sv
// tb/tb_tri_seq_monitor.sv - randomized bench for tri_seq_monitor against a sequence model
// Define TRI_SEQ_MONITOR_ERR_CNT_EN to also exercise err_cnt.
module tb_tri_seq_monitor;
   localparam int W   = 3;
   localparam int MIN = 0;
   localparam int MAX = 5;
   localparam int PW  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   tri_seq_monitor_if #(.W(W), .PW(PW)) bus ();

   tri_seq_monitor #(.W(W), .MIN(MIN), .MAX(MAX), .PW(PW)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: have_prev/locked/going_down flags, integer arithmetic.
   bit m_have, m_lock, m_down, m_top, m_bot, m_err, m_sticky;
   int m_prev, m_period, m_errcnt;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int tri_val(input int p);
      int span = MAX - MIN;
      int q = p % (2 * span);
      return MIN + ((q <= span) ? q : 2 * span - q);
   endfunction

   task automatic model_step(input bit r, input bit v, input int s);
      if (r) begin
         m_have = 0; m_lock = 0; m_down = 0; m_top = 0; m_bot = 0;
         m_err = 0; m_sticky = 0; m_prev = 0; m_period = 0; m_errcnt = 0;
         return;
      end
      m_top = 0; m_bot = 0; m_err = 0;
      if (!v) return;
      if (!m_have) begin
         m_have = 1;
      end else if (!m_lock) begin
         if (s == m_prev + 1 && s <= MAX) begin
            m_lock = 1; m_down = (s == MAX);
            m_top = (s == MAX); m_bot = (s == MIN);
         end else if (s == m_prev - 1 && s >= MIN) begin
            m_lock = 1; m_down = (s != MIN);
            m_top = (s == MAX); m_bot = (s == MIN);
         end
      end else begin
         if (s == (m_down ? m_prev - 1 : m_prev + 1) && s >= MIN && s <= MAX) begin
            if (!m_down && s == MAX) begin
               m_down = 1; m_top = 1;
            end else if (m_down && s == MIN) begin
               m_down = 0; m_bot = 1; m_period = (m_period + 1) % (1 << PW);
            end
         end else begin
            m_err = 1; m_sticky = 1; m_lock = 0; m_down = 0;
            if (m_errcnt < 255) m_errcnt++;
         end
      end
      m_prev = s;
   endtask

   task automatic compare_all();
      chk("dir",        int'(bus.dir),        int'(m_down && m_lock));
      chk("locked",     int'(bus.locked),     int'(m_lock));
      chk("at_top",     int'(bus.at_top),     int'(m_top));
      chk("at_bot",     int'(bus.at_bot),     int'(m_bot));
      chk("err",        int'(bus.err),        int'(m_err));
      chk("err_sticky", int'(bus.err_sticky), int'(m_sticky));
      chk("period_cnt", int'(bus.period_cnt), m_period);
`ifdef TRI_SEQ_MONITOR_ERR_CNT_EN
      chk("err_cnt",    int'(bus.err_cnt),    m_errcnt);
`endif
   endtask

   task automatic cyc(input bit r, input bit v, input int s);
      rst         = r;
      bus.cnt_vld = v;
      bus.cnt_in  = W'(s);
      @(posedge clk);
      model_step(r, v, s);
      #1;
      compare_all();
   endtask

   task automatic expect_reset_outputs(input string tag);
      chk({tag, "_dir"},    int'(bus.dir),        0);
      chk({tag, "_locked"}, int'(bus.locked),     0);
      chk({tag, "_top"},    int'(bus.at_top),     0);
      chk({tag, "_bot"},    int'(bus.at_bot),     0);
      chk({tag, "_err"},    int'(bus.err),        0);
      chk({tag, "_sticky"}, int'(bus.err_sticky), 0);
      chk({tag, "_period"}, int'(bus.period_cnt), 0);
   endtask

   initial begin
      int ph;
      bus.cnt_in  = '0;
      bus.cnt_vld = 1'b0;

      cyc(1, 1, 3);
      expect_reset_outputs("reset");

      // single clean period
      for (int p = 0; p <= 2 * (MAX - MIN); p++) begin
         cyc(0, 1, tri_val(p));
         if (p == 1) chk("lock_after_1", int'(bus.locked), 1);
         if (p == 5) chk("top_after_5", int'(bus.at_top), 1);
      end
      chk("bot_final", int'(bus.at_bot), 1);
      chk("period_one", int'(bus.period_cnt), 1);

      // 300 periods wrap the 8-bit counter
      cyc(1, 0, 0);
      for (int p = 0; p <= 300 * 2 * (MAX - MIN); p++) cyc(0, 1, tri_val(p));
      chk("period_wrap", int'(bus.period_cnt), 44);
      chk("wrap_sticky", int'(bus.err_sticky), 0);

      // jump error from UP at 3, then relock downwards
      cyc(1, 0, 0);
      for (int v = 0; v <= 3; v++) cyc(0, 1, v);
      cyc(0, 1, 5);
      chk("inj_err", int'(bus.err), 1);
      chk("inj_unlock", int'(bus.locked), 0);
      cyc(0, 1, 4);
      cyc(0, 1, 3);
      chk("relock_dir", int'(bus.dir), 1);
      chk("relock_err", int'(bus.err), 0);
      chk("relock_sticky", int'(bus.err_sticky), 1);

      // 50% valid on a clean sequence
      cyc(1, 0, 0);
      ph = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            cyc(0, 1, tri_val(ph));
            ph++;
         end else begin
            cyc(0, 0, $urandom_range((1 << W) - 1, 0));
         end
      end

      // reset mid-period while DOWN at 4
      cyc(1, 0, 0);
      for (int p = 0; p <= 6; p++) cyc(0, 1, tri_val(p));
      chk("pre_rst_dir", int'(bus.dir), 1);
      cyc(1, 1, 3);
      expect_reset_outputs("midrst");
      cyc(0, 1, 2);
      cyc(0, 1, 1);
      chk("resume_dir", int'(bus.dir), 1);
      cyc(0, 1, 0);
      chk("resume_bot", int'(bus.at_bot), 1);

      // random mix of clean steps, noise, gaps and rare resets
      ph = 0;
      for (int i = 0; i < 3000; i++) begin
         int sel = $urandom_range(99, 0);
         if (sel < 2)       cyc(1, $urandom_range(1, 0), $urandom_range(7, 0));
         else if (sel < 25) cyc(0, 0, $urandom_range(7, 0));
         else if (sel < 35) cyc(0, 1, $urandom_range(7, 0));
         else begin
            cyc(0, 1, tri_val(ph));
            ph++;
         end
      end

`ifdef TRI_SEQ_MONITOR_ERR_CNT_EN
      cyc(1, 0, 0);
      cyc(0, 1, 2);
      for (int i = 0; i < 260; i++) begin
         cyc(0, 1, (i % 2 == 0) ? 3 : 2);
         cyc(0, 1, (i % 2 == 0) ? 3 : 2);
      end
      chk("err_cnt_sat", int'(bus.err_cnt), 255);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/tri_seq_monitor.md
Name: tri_seq_monitor

Overview:
- Downstream checker for a bouncing (triangle) up/down counter such as the 0,1,2,3,4,5,4,3,2,1 sequence generator.
- Samples the counter value on each valid cycle, tracks the counting direction, and flags any step that breaks the triangle sequence.
- Counts completed periods and emits turn-point pulses for downstream logic, for example waveform-phase or PWM alignment.
- Sits directly on the counter's output bus.

Parameters:
- W, 3, width of the monitored count.
- MIN, 0, bottom turning value.
- MAX, 5, top turning value; MIN < MAX <= 2**W-1 is required.
- PW, 8, width of the period counter.

Ports:
- clk  input  1  clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- cnt_in  input  W  counter value under test.
- cnt_vld  input  1  cnt_in is sampled only when this is 1.
- dir  output  1  tracked direction: 0 = up, 1 = down.
- locked  output  1  monitor is in UP or DOWN state.
- at_top  output  1  1-cycle pulse when an accepted sample equals MAX.
- at_bot  output  1  1-cycle pulse when an accepted sample equals MIN.
- err  output  1  1-cycle pulse on a sequence violation.
- err_sticky  output  1  set by err; cleared only by rst.
- period_cnt  output  PW  number of completed periods (MIN to MAX to MIN), wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on posedge clk.
- Reset values: state=IDLE, prev=0, dir=0, locked=0, at_top=0, at_bot=0, err=0, err_sticky=0, period_cnt=0.
- Reset wins over cnt_vld in the same cycle. Reset mid-period discards all history.
- Latency: outputs are registered and reflect the sample taken on the previous edge with cnt_vld=1.
- When cnt_vld=0: state, prev, dir and period_cnt hold; at_top, at_bot and err are 0.
- An accepted sample is any sample taken with cnt_vld=1 that is not an error. Every accepted sample updates prev to cnt_in.
- State machine:
  - IDLE: the first valid sample loads prev and moves to ACQ. No checking in IDLE.
  - ACQ: a valid sample s is classified against prev.
    - s==prev+1 and s<=MAX: go to UP, or to DOWN if s==MAX.
    - s==prev-1 and s>=MIN: go to DOWN, or to UP if s==MIN.
    - Anything else: stay in ACQ, load prev=s, no err pulse (not yet locked).
  - UP: the expected value is prev+1.
    - A match with s==MAX goes to DOWN and pulses at_top.
    - Any other match stays in UP.
  - DOWN: the expected value is prev-1.
    - A match with s==MIN goes to UP, pulses at_bot, and increments period_cnt (modulo 2**PW).
    - Any other match stays in DOWN.
  - Mismatch in UP or DOWN: err=1 for one cycle, err_sticky=1, go to ACQ, prev=s, period_cnt holds.
- dir=1 exactly when the state is DOWN. locked=1 exactly when the state is UP or DOWN.
- Out-of-range values: a value outside [MIN,MAX] in UP or DOWN is a mismatch.
- Arithmetic: prev+1 and prev-1 are computed at W+1 bits, so there is no wrap; 0-1 never matches.
- Turn-point pulses: at_top and at_bot also pulse on the ACQ to lock transition if s equals MAX or MIN. period_cnt does not increment on that transition.
- Held input: a repeated value while cnt_vld=1 is a mismatch in UP or DOWN.

Optional Feature:
- Macro: TRI_SEQ_MONITOR_ERR_CNT_EN.
- When defined: adds output port err_cnt (8 bits). It increments on every err pulse, saturates at 255, and resets to 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then cnt_in = 0,1,2,3,4,5,4,3,2,1,0 with cnt_vld=1 every cycle -> locked=1 one cycle after sample 1. at_top pulses after 5. at_bot pulses after the final 0. period_cnt=1. err never asserts.
- Run 300 clean periods -> period_cnt wraps to 300 mod 256 = 44. err_sticky=0.
- Locked in UP at 3, then inject 5 -> err pulse, err_sticky=1, locked=0. Follow with 4,3 -> relocks in DOWN, dir=1, no further err.
- Toggle cnt_vld at 50% with a clean sequence -> identical flags per accepted sample. No pulses on cycles with cnt_vld=0.
- Assert rst mid-period at value 4 while DOWN -> next cycle all outputs are at their reset values. Resume at 2,1 -> locks DOWN, and at_bot pulses on the following 0.
- With TRI_SEQ_MONITOR_ERR_CNT_EN defined, inject 260 errors -> err_cnt=255.
